// File: rtl/wb_sw_reg_arbiter.sv
// Round-robin Wishbone arbiter: N flattened master buses share one slave bus.
// A per-transfer watchdog aborts a strobe the slave never answers and returns err to the master.
module wb_sw_reg_arbiter #(
    parameter int unsigned C_NUM_MASTERS   = 2,
    parameter int unsigned C_WB_DATA_WIDTH = 32,
    parameter int unsigned C_WB_ADDR_WIDTH = 32,
    parameter int unsigned C_BYTE_EN_WIDTH = 4,
    parameter int unsigned C_TIMEOUT       = 255
) (
    input  logic                                         wb_clk_i,
    input  logic                                         wb_rst_i,
    input  logic [C_NUM_MASTERS-1:0]                     m_cyc_i,
    input  logic [C_NUM_MASTERS-1:0]                     m_stb_i,
    input  logic [C_NUM_MASTERS-1:0]                     m_we_i,
    input  logic [C_NUM_MASTERS*C_BYTE_EN_WIDTH-1:0]     m_sel_i,
    input  logic [C_NUM_MASTERS*C_WB_ADDR_WIDTH-1:0]     m_adr_i,
    input  logic [C_NUM_MASTERS*C_WB_DATA_WIDTH-1:0]     m_dat_i,
    output logic [C_WB_DATA_WIDTH-1:0]                   m_dat_o,
    output logic [C_NUM_MASTERS-1:0]                     m_ack_o,
    output logic [C_NUM_MASTERS-1:0]                     m_err_o,
    output logic                                         s_cyc_o,
    output logic                                         s_stb_o,
    output logic                                         s_we_o,
    output logic [C_BYTE_EN_WIDTH-1:0]                   s_sel_o,
    output logic [C_WB_ADDR_WIDTH-1:0]                   s_adr_o,
    output logic [C_WB_DATA_WIDTH-1:0]                   s_dat_o,
    input  logic [C_WB_DATA_WIDTH-1:0]                   s_dat_i,
    input  logic                                         s_ack_i,
    input  logic                                         s_err_i,
    output logic [((C_NUM_MASTERS > 1) ? $clog2(C_NUM_MASTERS) : 1)-1:0] grant_o
);

    localparam int unsigned N  = C_NUM_MASTERS;
    localparam int unsigned DW = C_WB_DATA_WIDTH;
    localparam int unsigned AW = C_WB_ADDR_WIDTH;
    localparam int unsigned BW = C_BYTE_EN_WIDTH;
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [TW-1:0]   cnt_q, cnt_d;

    logic [BW-1:0]   sel_a [N];
    logic [AW-1:0]   adr_a [N];
    logic [DW-1:0]   dat_a [N];

    logic            g_cyc, g_stb, g_we;
    logic [BW-1:0]   g_sel;
    logic [AW-1:0]   g_adr;
    logic [DW-1:0]   g_dat;

    logic            found;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand;

    // Unflatten the per-master vectors so the granted master can be indexed directly.
    for (genvar i = 0; i < int'(N); i++) begin : g_unpack
        assign sel_a[i] = m_sel_i[i*BW +: BW];
        assign adr_a[i] = m_adr_i[i*AW +: AW];
        assign dat_a[i] = m_dat_i[i*DW +: DW];
    end

    always_comb begin
        g_cyc = m_cyc_i[grant_q];
        g_stb = m_stb_i[grant_q];
        g_we  = m_we_i[grant_q];
        g_sel = sel_a[grant_q];
        g_adr = adr_a[grant_q];
        g_dat = dat_a[grant_q];
    end

    // Round-robin search: first requester after the previous winner, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = last_q;
        for (int k = 1; k <= int'(N); k++) begin
            cand = GW'((int'(last_q) + k) % int'(N));
            if (!found && m_cyc_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    last_d  = pick;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A cyc drop outranks an expiring watchdog.
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                end else if (g_stb && !s_ack_i && !s_err_i) begin
                    if (cnt_q >= TW'(C_TIMEOUT)) begin
                        state_d = ST_ABORT;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
            end
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slave port follows the grantee only in BUSY; ABORT signals err from the registered state.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        case (state_q)
            ST_BUSY: begin
                s_cyc_o          = g_cyc;
                s_stb_o          = g_stb;
                s_we_o           = g_we;
                s_sel_o          = g_sel;
                s_adr_o          = g_adr;
                s_dat_o          = g_dat;
                m_ack_o[grant_q] = s_ack_i;
                m_err_o[grant_q] = s_err_i;
                m_dat_o          = s_dat_i;
            end
            ST_ABORT: begin
                m_err_o[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant_o = grant_q;

endmodule
